muxn_pipe: RTL and testbench

MUXN_PIPE -- requirements
Module: muxn_pipe

---
 rtl/muxn_pipe.sv | 132 +++++++++++++
 tb/tb_muxn_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/muxn_pipe.sv
// ============================================================================
// Module  : muxn_pipe
// Brief   : N-channel valid/ready multiplexer with a one-deep registered
//           output stage. Select mode picks channel 'sel'; when the macro
//           MUXN_PIPE_RR_EN is defined, mode=1 enables round-robin arbitration.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module muxn_pipe #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_src
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]      state;
    logic [0:0]      next_state;
    logic            can_accept;
    logic [SELW-1:0] pick;
    logic            pick_valid;
    logic            xfer;

`ifdef MUXN_PIPE_RR_EN
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] grant;
    logic            grant_found;

    // Scan downward from the farthest offset so the nearest valid channel
    // at or above ptr is the last (and winning) assignment.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (in_valid[ptr + SELW'(j)]) begin
                grant       = ptr + SELW'(j);
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        pick       = mode ? grant : sel;
        pick_valid = mode ? grant_found : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (xfer && mode) begin
            ptr <= grant + SELW'(1);
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;

    always_comb begin
        pick       = sel;
        pick_valid = 1'b1;
    end
`endif

    assign xfer = in_valid[pick] & can_accept & pick_valid & ~reset;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            EMPTY: begin
                if (xfer) begin
                    next_state = FULL;
                end
            end
            FULL: begin
                if (xfer) begin
                    next_state = FULL;
                end else if (out_ready) begin
                    next_state = EMPTY;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    // Output logic
    always_comb begin
        out_valid  = (state == FULL);
        can_accept = (state == EMPTY) | out_ready;
        in_ready   = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = can_accept & pick_valid & ~reset & (pick == SELW'(i));
        end
    end

    // Payload register holds its value when not loading, including while EMPTY.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data <= '0;
            out_src  <= '0;
        end else if (xfer) begin
            out_data <= in_data[pick*WIDTH +: WIDTH];
            out_src  <= pick;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muxn_pipe.sv
// ============================================================================
// Module  : tb_muxn_pipe
// Brief   : Directed self-checking bench for muxn_pipe (WIDTH=32, N=4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muxn_pipe;

    localparam int WIDTH = 32;
    localparam int N     = 4;

    logic              clk;
    logic              reset;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [1:0]        sel;
    logic              mode;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_src;

    int total;
    int bad;

    muxn_pipe #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [WIDTH-1:0] val);
        in_data[ch*WIDTH +: WIDTH] = val;
    endtask

    task automatic test_reset();
        reset = 1'b1; mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        step();
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
        total++; if (out_src !== 2'd0) begin bad++; $display("FAIL reset_src got=%0d exp=0", out_src); end
        total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", in_ready); end
    endtask

    task automatic test_select();
        for (int i = 0; i < N; i++) set_ch(i, 32'hCAFE0000 + i);
        reset = 1'b0; mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL sel_ready got=%b exp=0100", in_ready); end
        step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sel_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 32'hCAFE0002) begin bad++; $display("FAIL sel_data got=%h exp=cafe0002", out_data); end
        total++; if (out_src !== 2'd2) begin bad++; $display("FAIL sel_src got=%0d exp=2", out_src); end
    endtask

    task automatic test_hold();
        out_ready = 1'b0; set_ch(2, 32'h0); sel = 2'd1;
        #1;
        total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL hold_ready0 got=%b exp=0000", in_ready); end
        for (int c = 0; c < 3; c++) begin
            step();
            total++; if (out_data !== 32'hCAFE0002) begin bad++; $display("FAIL hold_data cyc=%0d got=%h exp=cafe0002", c, out_data); end
            total++; if (out_src !== 2'd2 || out_valid !== 1'b1) begin bad++; $display("FAIL hold_src cyc=%0d got=%0d/%b exp=2/1", c, out_src, out_valid); end
            total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL hold_ready cyc=%0d got=%b exp=0000", c, in_ready); end
        end
    endtask

    task automatic test_deliver();
        out_ready = 1'b1; in_valid = 4'b0000;
        #1;
        total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL dlv_ready got=%b exp=0010", in_ready); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dlv_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 32'hCAFE0002) begin bad++; $display("FAIL dlv_retain got=%h exp=cafe0002", out_data); end
    endtask

    task automatic test_back_to_back();
        set_ch(1, 32'h11110001); set_ch(3, 32'h33330003);
        in_valid = 4'b1111; sel = 2'd1; out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b1 || out_data !== 32'h11110001) begin bad++; $display("FAIL b2b_first got=%b/%h exp=1/11110001", out_valid, out_data); end
        sel = 2'd3;
        #1;
        total++; if (in_ready !== 4'b1000) begin bad++; $display("FAIL b2b_ready got=%b exp=1000", in_ready); end
        step();
        total++; if (out_valid !== 1'b1 || out_data !== 32'h33330003 || out_src !== 2'd3) begin bad++; $display("FAIL b2b_second got=%b/%h/%0d exp=1/33330003/3", out_valid, out_data, out_src); end
    endtask

    task automatic test_reset_full();
        set_ch(0, 32'h12345678); sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
        step();
        total++; if (out_data !== 32'h12345678 || out_valid !== 1'b1) begin bad++; $display("FAIL rf_load got=%h/%b exp=12345678/1", out_data, out_valid); end
        reset = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL rf_ready got=%b exp=0000", in_ready); end
        step();
        total++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_src !== 2'd0) begin bad++; $display("FAIL rf_clear got=%b/%h/%0d exp=0/0/0", out_valid, out_data, out_src); end
        reset = 1'b0; sel = 2'd3; in_valid = 4'b1000; set_ch(3, 32'hABCD0003);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rf_idle got=%b exp=0", out_valid); end
        step();
        total++; if (out_valid !== 1'b1 || out_data !== 32'hABCD0003 || out_src !== 2'd3) begin bad++; $display("FAIL rf_fresh got=%b/%h/%0d exp=1/abcd0003/3", out_valid, out_data, out_src); end
    endtask

    task automatic test_mode_sel3();
        mode = 1'b1; sel = 2'd3; in_valid = 4'b1000; out_ready = 1'b1; set_ch(3, 32'h0000BEEF);
        #1;
        total++; if (in_ready !== 4'b1000) begin bad++; $display("FAIL m1_ready got=%b exp=1000", in_ready); end
        step();
        total++; if (out_src !== 2'd3 || out_data !== 32'h0000BEEF) begin bad++; $display("FAIL m1_src got=%0d/%h exp=3/0000beef", out_src, out_data); end
    endtask

`ifdef MUXN_PIPE_RR_EN
    task automatic test_round_robin();
        logic [1:0] exp_src [6];
        exp_src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int i = 0; i < N; i++) set_ch(i, 32'hAA000000 + i);
        reset = 1'b1; step(); reset = 1'b0;
        mode = 1'b1; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            total++;
            if (out_valid !== 1'b1 || out_src !== exp_src[c] || out_data !== (32'hAA000000 + 32'(exp_src[c]))) begin
                bad++; $display("FAIL rr_seq cyc=%0d got=%b/%0d/%h exp=1/%0d", c, out_valid, out_src, out_data, exp_src[c]);
            end
        end
    endtask

    task automatic test_rr_wrap();
        reset = 1'b1; step(); reset = 1'b0;
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        step(); step(); step();
        in_valid = 4'b0110;
        #1;
        total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL rrw_ready got=%b exp=0010", in_ready); end
        step();
        total++; if (out_src !== 2'd1) begin bad++; $display("FAIL rrw_grant1 got=%0d exp=1", out_src); end
        total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL rrw_ready2 got=%b exp=0100", in_ready); end
        step();
        total++; if (out_src !== 2'd2) begin bad++; $display("FAIL rrw_grant2 got=%0d exp=2", out_src); end
    endtask
`else
    task automatic test_mode_ignored();
        mode = 1'b1; sel = 2'd1; in_valid = 4'b1111; out_ready = 1'b1; set_ch(1, 32'h5555AAAA);
        #1;
        total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL mign_ready got=%b exp=0010", in_ready); end
        step();
        total++; if (out_src !== 2'd1 || out_data !== 32'h5555AAAA) begin bad++; $display("FAIL mign_src got=%0d/%h exp=1/5555aaaa", out_src, out_data); end
        step();
        total++; if (out_src !== 2'd1) begin bad++; $display("FAIL mign_repeat got=%0d exp=1", out_src); end
    endtask
`endif

    initial begin
        total = 0; bad = 0;
        in_data = '0;
        @(negedge clk);
        test_reset();
        test_select();
        test_hold();
        test_deliver();
        test_back_to_back();
        test_reset_full();
        test_mode_sel3();
`ifdef MUXN_PIPE_RR_EN
        test_round_robin();
        test_rr_wrap();
`else
        test_mode_ignored();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
